// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath stages (ReLU, max-pool).
package cnn_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH    = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH    = 8;
  localparam int unsigned DEFAULT_DATABUS_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_MAT = 3'd1,
    COMPUTE  = 3'd2,
    WRITE    = 3'd3,
    FINISHED = 3'd4
  } state_t;

endpackage

// File: rtl/max4_signed.sv
// Combinational maximum of four signed operands.
module max4_signed
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  input  logic signed [DATA_WIDTH-1:0] c,
  input  logic signed [DATA_WIDTH-1:0] d,
  output logic signed [DATA_WIDTH-1:0] max_val
);

  logic signed [DATA_WIDTH-1:0] max_ab;
  logic signed [DATA_WIDTH-1:0] max_cd;

  // Two-level compare tree; ties simply pick the (equal) left operand.
  always_comb begin
    max_ab  = (a >= b) ? a : b;
    max_cd  = (c >= d) ? c : d;
    max_val = (max_ab >= max_cd) ? max_ab : max_cd;
  end

endmodule

// File: rtl/maxpool_with_mem.sv
// 2x2 stride-2 max-pool stage: loads a matrix over a shared memory bus,
// then writes the pooled result back row-major.
module maxpool_with_mem
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int DATABUS_WIDTH = DEFAULT_DATABUS_WIDTH,
  parameter int HEIGHT        = 4,
  parameter int WIDTH         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  input  logic [ADDR_WIDTH-1:0] input_addr,
  input  logic [ADDR_WIDTH-1:0] output_addr,
  output logic                  mem_w,
  output logic                  mem_sel,
  inout  wire [ADDR_WIDTH-1:0]    address_bus,
  inout  wire [DATABUS_WIDTH-1:0] data_bus
);

  localparam int unsigned RW = $clog2(HEIGHT);
  localparam int unsigned CW = $clog2(WIDTH);

  state_t state;
  state_t state_next;

  logic [ADDR_WIDTH-1:0]    address;
  logic [DATABUS_WIDTH-1:0] data;
  logic [RW-1:0]            row;
  logic [CW-1:0]            col;
  logic [RW-1:0]            wy;
  logic [CW-1:0]            wx;

  logic signed [DATA_WIDTH-1:0] matrix [HEIGHT][WIDTH];

  logic                         load_last;
  logic                         row_end;
  logic                         win_col_last;
  logic                         win_last;
  logic [RW-1:0]                r0;
  logic [RW-1:0]                r1;
  logic [CW-1:0]                c0;
  logic [CW-1:0]                c1;
  logic signed [DATA_WIDTH-1:0] max_val;

  // Position flags and the window's top-left/bottom-right element indices.
  always_comb begin
    row_end      = (col == CW'(WIDTH - 1));
    load_last    = row_end && (row == RW'(HEIGHT - 1));
    win_col_last = (wx == CW'(WIDTH / 2 - 1));
    win_last     = win_col_last && (wy == RW'(HEIGHT / 2 - 1));
    r0           = RW'({wy, 1'b0});
    r1           = RW'({wy, 1'b1});
    c0           = CW'({wx, 1'b0});
    c1           = CW'({wx, 1'b1});
  end

  max4_signed #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_max4 (
    .a       (matrix[r0][c0]),
    .b       (matrix[r0][c1]),
    .c       (matrix[r1][c0]),
    .d       (matrix[r1][c1]),
    .max_val (max_val)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic and the state-decoded done flag.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE:     if (start) state_next = LOAD_MAT;
      LOAD_MAT: if (load_last) state_next = COMPUTE;
      COMPUTE:  state_next = WRITE;
      WRITE:    state_next = win_last ? FINISHED : COMPUTE;
      FINISHED: begin
        done = 1'b1;
        if (!start) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  // Address, data, bus-control and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      address <= '0;
      data    <= '0;
      mem_w   <= 1'b0;
      mem_sel <= 1'b0;
      row     <= '0;
      col     <= '0;
      wy      <= '0;
      wx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            address <= input_addr;
            mem_sel <= 1'b1;
            mem_w   <= 1'b0;
            row     <= '0;
            col     <= '0;
          end
        end
        LOAD_MAT: begin
          if (load_last) begin
            address <= output_addr;
            mem_sel <= 1'b0;
            wy      <= '0;
            wx      <= '0;
          end else begin
            address <= address + ADDR_WIDTH'(1);
            if (row_end) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        COMPUTE: begin
          data  <= DATABUS_WIDTH'(max_val);
          mem_w <= 1'b1;
        end
        WRITE: begin
          mem_w   <= 1'b0;
          address <= address + ADDR_WIDTH'(1);
          if (win_col_last) begin
            wx <= '0;
            wy <= wy + RW'(1);
          end else begin
            wx <= wx + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Element capture; memory returns read data combinationally.
  always_ff @(posedge clk) begin
    if (state == LOAD_MAT) matrix[row][col] <= data_bus[DATA_WIDTH-1:0];
  end

  assign address_bus = (state == LOAD_MAT || state == WRITE) ? address : 'z;
  assign data_bus    = (state == WRITE && mem_w) ? data : 'z;

  // Only the low element bits of the bus are meaningful on reads.
  if (DATABUS_WIDTH > DATA_WIDTH) begin : g_unused
    logic unused_upper;
    assign unused_upper = ^data_bus[DATABUS_WIDTH-1:DATA_WIDTH];
  end

endmodule

// File: tb/tb_maxpool_with_mem.sv
// Self-checking bench for maxpool_with_mem with a behavioural memory model.
module tb_maxpool_with_mem;

  localparam int H   = 4;
  localparam int W   = 4;
  localparam int LAT = 1 + H * W + 2 * (H / 2) * (W / 2);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [7:0]  input_addr = '0;
  logic [7:0]  output_addr = '0;
  logic        mem_w;
  logic        mem_sel;
  wire  [7:0]  address_bus;
  wire  [31:0] data_bus;

  logic [31:0] mem [256];
  logic [7:0]  rq [$];
  logic [39:0] wq [$];
  logic [39:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] Z8  = {24'd0, {8{1'bz}}};
  localparam logic [31:0] Z32 = {32{1'bz}};

  maxpool_with_mem #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (8),
    .DATABUS_WIDTH (32),
    .HEIGHT        (H),
    .WIDTH         (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .done        (done),
    .input_addr  (input_addr),
    .output_addr (output_addr),
    .mem_w       (mem_w),
    .mem_sel     (mem_sel),
    .address_bus (address_bus),
    .data_bus    (data_bus)
  );

  always #5 clk = ~clk;

  assign data_bus = (mem_sel === 1'b1 && mem_w === 1'b0) ? mem[address_bus] : 'z;

  always @(posedge clk) begin
    if (mem_sel === 1'b1 && mem_w === 1'b0) rq.push_back(address_bus);
    if (mem_w === 1'b1) wq.push_back({address_bus, data_bus});
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void build_expect(input logic [7:0] in_a, input logic [7:0] out_a);
    exp_q.delete();
    for (int wy = 0; wy < H / 2; wy++) begin
      for (int wx = 0; wx < W / 2; wx++) begin
        int best;
        best = -1000;
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            logic [7:0]        a;
            logic signed [7:0] v;
            int                vi;
            a  = in_a + 8'((2 * wy + dy) * W + 2 * wx + dx);
            v  = mem[a][7:0];
            vi = v;
            if (vi > best) best = vi;
          end
        end
        exp_q.push_back({8'(out_a + 8'(wy * (W / 2) + wx)), 32'(best)});
      end
    end
  endfunction

  task automatic set_elem(input logic [7:0] a, input logic [7:0] v);
    logic [31:0] r;
    r = $urandom();
    mem[a] = {r[31:8], v};
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_done"},    40'(done), 40'(0));
    check({tag, "_mem_w"},   40'(mem_w), 40'(0));
    check({tag, "_mem_sel"}, 40'(mem_sel), 40'(0));
    check({tag, "_addr_z"},  40'(Z8), {8'd0, Z8});
    check({tag, "_addr_z"},  {8'd0, 24'd0, address_bus}, {8'd0, Z8});
    check({tag, "_data_z"},  {8'd0, data_bus}, {8'd0, Z32});
  endtask

  task automatic run_pass(input string tag, input logic [7:0] in_a,
                          input logic [7:0] out_a, input int hold);
    int edges;
    int rbase;
    int wbase;
    build_expect(in_a, out_a);
    rbase = rq.size();
    wbase = wq.size();
    @(negedge clk);
    input_addr  = in_a;
    output_addr = out_a;
    start       = 1'b1;
    @(posedge clk);
    edges = 1;
    #1;
    while (done !== 1'b1 && edges < 200) begin
      if (edges == 1) begin
        check({tag, "_load_sel"}, 40'(mem_sel), 40'(1));
        check({tag, "_load_addr"}, 40'(address_bus), 40'(in_a));
      end
      if (edges == 1 + H * W) begin
        check({tag, "_cmp_addr_z"}, {8'd0, 24'd0, address_bus}, {8'd0, Z8});
        check({tag, "_cmp_data_z"}, {8'd0, data_bus}, {8'd0, Z32});
      end
      @(posedge clk);
      edges++;
      #1;
    end
    check({tag, "_latency"}, 40'(edges), 40'(LAT));
    check({tag, "_fin_addr_z"}, {8'd0, 24'd0, address_bus}, {8'd0, Z8});
    check({tag, "_fin_data_z"}, {8'd0, data_bus}, {8'd0, Z32});
    check({tag, "_nreads"}, 40'(rq.size() - rbase), 40'(H * W));
    for (int k = 0; k < H * W && rbase + k < rq.size(); k++)
      check({tag, "_rd_addr"}, 40'(rq[rbase + k]), 40'(8'(in_a + 8'(k))));
    check({tag, "_nwrites"}, 40'(wq.size() - wbase), 40'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && wbase + k < wq.size(); k++)
      check({tag, "_wr"}, wq[wbase + k], exp_q[k]);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_done"}, 40'(done), 40'(1));
    end
    check({tag, "_hold_noreads"}, 40'(rq.size() - rbase), 40'(H * W));
    check({tag, "_hold_nowrites"}, 40'(wq.size() - wbase), 40'(exp_q.size()));
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_done_fall"}, 40'(done), 40'(0));
    @(posedge clk);
    #1;
    check({tag, "_no_retrig"}, 40'(mem_sel), 40'(0));
  endtask

  initial begin
    int edges;
    int wbase;
    for (int a = 0; a < 256; a++) mem[a] = $urandom();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("idle");

    // 4x4 ramp 1..16
    for (int k = 0; k < 16; k++) set_elem(8'(k), 8'(k + 1));
    wbase = wq.size();
    run_pass("ramp", 8'h00, 8'h40, 0);
    check("ramp_w0", wq[wbase + 0], {8'h40, 32'd6});
    check("ramp_w3", wq[wbase + 3], {8'h43, 32'd16});

    // Directed windows: negatives, zeros, extremes, ties
    begin
      logic [7:0] vals [16];
      vals = '{8'hFB, 8'hFD, 8'h00, 8'h00,
               8'hF8, 8'hFF, 8'h00, 8'h00,
               8'h7F, 8'h80, 8'h07, 8'h07,
               8'h7F, 8'h00, 8'hFE, 8'h07};
      for (int k = 0; k < 16; k++) set_elem(8'(8'h10 + k), vals[k]);
    end
    wbase = wq.size();
    run_pass("win", 8'h10, 8'h80, 0);
    check("win_neg",  wq[wbase + 0], {8'h80, 32'hFFFF_FFFF});
    check("win_zero", wq[wbase + 1], {8'h81, 32'h0000_0000});
    check("win_ext",  wq[wbase + 2], {8'h82, 32'h0000_007F});
    check("win_tie",  wq[wbase + 3], {8'h83, 32'h0000_0007});

    // Reset mid-load
    wbase = wq.size();
    @(negedge clk);
    input_addr  = 8'h20;
    output_addr = 8'h60;
    start       = 1'b1;
    @(posedge clk);
    edges = 1;
    while (edges < 10) begin
      @(posedge clk);
      edges++;
    end
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    check("midrst_nowrites", 40'(wq.size() - wbase), 40'(0));
    check("midrst_sel", 40'(mem_sel), 40'(0));
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    run_pass("after_rst", 8'h20, 8'h60, 0);

    // start held through FINISHED
    run_pass("hold", 8'($urandom()), 8'($urandom()), 5);

    // Address wrap on reads and writes
    run_pass("wrap", 8'hFE, 8'hFD, 0);

    // Random contents and addresses
    for (int p = 0; p < 4; p++) begin
      for (int a = 0; a < 256; a++) mem[a] = $urandom();
      run_pass("rand", 8'($urandom()), 8'($urandom()), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
